// File: rtl/mul_seq.sv
// Sequential 32x32 -> low-32 unsigned multiplier built around one shared mul16.
// Up to three partial products (LL, LH, HL) are accumulated. The overflow flag is exact.

module mul16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = {16'b0, a} * {16'b0, b};
endmodule

module mul_seq #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LL, LH, HL, DONE} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } ops_t;

  state_t      state;
  ops_t        op;
  logic [33:0] acc;
  logic        hiovf;

  logic [15:0] ma, mb;
  logic [31:0] p;
  logic [33:0] acc_nxt;
  logic        hiovf_nxt;
  logic        accept, early;

  assign req_ready = !rst && (state == IDLE || (state == DONE && resp_ready));
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign early     = EARLY_OUT && (op.a[31:16] == 16'd0) && (op.b[31:16] == 16'd0);

  always_comb begin
    ma = 16'd0;
    mb = 16'd0;
    case (state)
      LL: begin ma = op.a[15:0];  mb = op.b[15:0];  end
      LH: begin ma = op.a[15:0];  mb = op.b[31:16]; end
      HL: begin ma = op.a[31:16]; mb = op.b[15:0];  end
      default: ;
    endcase
  end

  mul16 u_mul (.a(ma), .b(mb), .p(p));

  // Cross products only contribute their low half to the 32-bit result.
  // Any nonzero upper half, or hi*hi, means the full product overflows.
  always_comb begin
    acc_nxt   = acc;
    hiovf_nxt = hiovf;
    case (state)
      LL: begin
        acc_nxt   = {2'b0, p};
        hiovf_nxt = (|op.a[31:16]) && (|op.b[31:16]);
      end
      LH, HL: begin
        acc_nxt   = acc + {2'b0, p[15:0], 16'b0};
        hiovf_nxt = hiovf | (|p[31:16]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op         <= '0;
      acc        <= '0;
      hiovf      <= 1'b0;
      resp_valid <= 1'b0;
      y          <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op    <= '{a: x1, b: x2};
            state <= LL;
          end
        end
        LL, LH, HL: begin
          acc   <= acc_nxt;
          hiovf <= hiovf_nxt;
          if (state == HL || (state == LL && early)) begin
            y          <= acc_nxt[31:0];
            ovf        <= hiovf_nxt | acc_nxt[33] | acc_nxt[32];
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            state <= (state == LL) ? LH : HL;
          end
        end
        DONE: begin
          // A request accepted here issues without an idle bubble.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (accept) begin
              op    <= '{a: x1, b: x2};
              state <= LL;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and randomized checks of mul_seq against a 64-bit arithmetic reference.

module tb_mul_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, resp_ready = 1'b0;
  logic [31:0] x1 = '0, x2 = '0;
  logic        req_ready, resp_valid, ovf, busy;
  logic [31:0] y;

  logic        req_valid0 = 1'b0, resp_ready0 = 1'b0;
  logic [31:0] x1_0 = '0, x2_0 = '0;
  logic        req_ready0, resp_valid0, ovf0, busy0;
  logic [31:0] y0;

  mul_seq #(.EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .x1(x1), .x2(x2), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .y(y), .ovf(ovf), .busy(busy)
  );

  mul_seq #(.EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .x1(x1_0), .x2(x2_0), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .y(y0), .ovf(ovf0), .busy(busy0)
  );

  int npass = 0, ntot = 0;
  int n, sent, got, cyc;
  logic        acc_now;
  logic [32:0] e;
  logic [32:0] q[$];

  logic [31:0] da[6] = '{32'h3, 32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'h0001FFFF, 32'h0000FFFF};
  logic [31:0] db[6] = '{32'h5, 32'hFFFFFFFF, 32'h00010000, 32'h00000002, 32'h0000FFFF, 32'h00010001};
  logic [31:0] dy[6] = '{32'hF, 32'h1, 32'h0, 32'h0, 32'hFFFD0001, 32'hFFFFFFFF};
  logic        dovf[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, low word} of the exact 64-bit product.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pr;
    pr = 64'(a) * 64'(b);
    return {pr[63:32] != 32'd0, pr[31:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(3, 0))
      0: v = v & 32'h0000FFFF;
      1: v = 32'hFFFFFFFF >> $urandom_range(31, 0);
      default: ;
    endcase
    return v;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ey, input logic eovf);
    int k, lat;
    lat = (a[31:16] == 16'd0 && b[31:16] == 16'd0) ? 1 : 3;
    req_valid = 1'b1; x1 = a; x2 = b;
    #1;
    chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0; x1 = $urandom; x2 = $urandom;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    k = 0;
    while (!resp_valid && k < 20) begin tick(); k++; end
    chk({tag, " latency"}, 64'(k), 64'(lat));
    chk({tag, " y"}, 64'(y), 64'(ey));
    chk({tag, " ovf"}, 64'(ovf), 64'(eovf));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, " resp_valid drop"}, 64'(resp_valid), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op0(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic eovf);
    int k;
    req_valid0 = 1'b1; x1_0 = a; x2_0 = b;
    #1;
    chk({tag, " req_ready"}, 64'(req_ready0), 64'd1);
    tick();
    req_valid0 = 1'b0; x1_0 = $urandom; x2_0 = $urandom;
    k = 0;
    while (!resp_valid0 && k < 20) begin tick(); k++; end
    chk({tag, " latency"}, 64'(k), 64'd3);
    chk({tag, " y"}, 64'(y0), 64'(ey));
    chk({tag, " ovf"}, 64'(ovf0), 64'(eovf));
    resp_ready0 = 1'b1;
    tick();
    resp_ready0 = 1'b0;
    chk({tag, " resp_valid drop"}, 64'(resp_valid0), 64'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst resp_valid", 64'(resp_valid), 64'd0);
    chk("rst y", 64'(y), 64'd0);
    chk("rst ovf", 64'(ovf), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst busy0", 64'(busy0), 64'd0);
    rst = 1'b0;
    #1;
    chk("post-rst req_ready", 64'(req_ready), 64'd1);

    // Directed vectors
    for (int i = 0; i < 6; i++)
      run_op($sformatf("dir%0d", i), da[i], db[i], dy[i], dovf[i]);
    run_op0("eo0 3*5", 32'd3, 32'd5, 32'hF, 1'b0);
    run_op0("eo0 ffff^2", 32'hFFFF, 32'hFFFF, 32'hFFFE0001, 1'b0);

    // Backpressure: response held while new requests are refused
    e = ref_mul(32'h12345678, 32'h9ABCDEF0);
    req_valid = 1'b1; x1 = 32'h12345678; x2 = 32'h9ABCDEF0;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    chk("bp latency", 64'(n), 64'd3);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; x1 = $urandom; x2 = $urandom;
      #1;
      chk("bp req_ready", 64'(req_ready), 64'd0);
      chk("bp resp_valid", 64'(resp_valid), 64'd1);
      chk("bp y", 64'(y), 64'(e[31:0]));
      chk("bp ovf", 64'(ovf), 64'(e[32]));
      tick();
    end
    resp_ready = 1'b1; x1 = 32'd7; x2 = 32'd9;
    #1;
    chk("bp release req_ready", 64'(req_ready), 64'd1);
    tick();
    resp_ready = 1'b0; req_valid = 1'b0; x1 = $urandom; x2 = $urandom;
    chk("bp no-bubble busy", 64'(busy), 64'd1);
    chk("bp old resp gone", 64'(resp_valid), 64'd0);
    tick();
    chk("bp next valid", 64'(resp_valid), 64'd1);
    chk("bp next y", 64'(y), 64'd63);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Random stream with consumer stalls
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 5000) begin
      if (!req_valid && sent < 100 && $urandom_range(3, 0) != 0) begin
        req_valid = 1'b1; x1 = rand_op(); x2 = rand_op();
      end
      resp_ready = ($urandom_range(2, 0) != 0);
      #1;
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) chk("stream unexpected resp", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("stream y", 64'(y), 64'(e[31:0]));
          chk("stream ovf", 64'(ovf), 64'(e[32]));
        end
        got++;
      end
      acc_now = req_valid && req_ready;
      if (acc_now) begin q.push_back(ref_mul(x1, x2)); sent++; end
      tick();
      if (acc_now) begin req_valid = 1'b0; x1 = $urandom; x2 = $urandom; end
      cyc++;
    end
    resp_ready = 1'b0; req_valid = 1'b0;
    chk("stream count", 64'(got), 64'd100);
    chk("stream drained", 64'(q.size()), 64'd0);
    tick();

    // Reset during LH abandons the operation
    req_valid = 1'b1; x1 = 32'hFFFFFFFF; x2 = 32'hFFFFFFFF;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst req_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst y", 64'(y), 64'd0);
    chk("midrst ovf", 64'(ovf), 64'd0);
    tick();
    chk("midrst no resp", 64'(resp_valid), 64'd0);
    run_op("after rst 7*6", 32'd7, 32'd6, 32'd42, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
